// File: rtl/fetch_unit.sv
// Instruction-fetch datapath (PC, MAR, MBR, IR) driven by CU strobes; all outputs registered, one edge after strobe.
// No backpressure: the CU owns sequencing. Optional sticky PC-wrap flag under FU_PC_WRAP_FLAG_EN.
module fetch_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic              fu_clk,
  input  logic              fu_rst,
  input  logic              mar_we,
  input  logic              mar_sel,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_ld_val,
  input  logic              mbr_we,
  input  logic              mbr_mux,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ir_we,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] fu_ir,
  output logic [DATA_W-1:0] fu_mbr,
  output logic [ADDR_W-1:0] fu_pc,
  output logic [CNT_W-1:0]  fu_icount,
  output logic              fu_err,
  output logic              fu_wrap
);

  logic [ADDR_W-1:0] pc, mar, pc_next, mar_src;
  logic [DATA_W-1:0] mbr, ir, mbr_src;
  logic [CNT_W-1:0]  icount;
  logic              err, err_set;

  always_comb begin
    mar_src = mar_sel ? {{(ADDR_W-4){1'b0}}, ir[3:0]} : pc;
    mbr_src = mbr_mux ? st_data : ram_rdata;
    pc_next = pc;
    if (pc_load)
      pc_next = pc_ld_val;
    else if (pc_inc)
      pc_next = pc + ADDR_W'(1);
    // operand fetch with an empty IR means the CU skipped the instruction fetch
    err_set = (pc_load & pc_inc) | (mar_we & mar_sel & (ir == '0));
  end

  always_ff @(posedge fu_clk or posedge fu_rst) begin
    if (fu_rst) begin
      pc     <= RESET_PC;
      mar    <= '0;
      mbr    <= '0;
      ir     <= '0;
      icount <= '0;
      err    <= 1'b0;
    end else begin
      pc <= pc_next;
      if (mar_we) mar <= mar_src;
      if (mbr_we) mbr <= mbr_src;
      if (ir_we)  ir  <= mbr;
      if (ir_we && icount != '1) icount <= icount + CNT_W'(1);
      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

`ifdef FU_PC_WRAP_FLAG_EN
  logic wrap, wrap_set;
  assign wrap_set = pc_inc & ~pc_load & (pc == '1);

  always_ff @(posedge fu_clk or posedge fu_rst) begin
    if (fu_rst)
      wrap <= 1'b0;
    else if (wrap_set)
      wrap <= 1'b1;
    else if (err_clr)
      wrap <= 1'b0;
  end

  assign fu_wrap = wrap;
`else
  assign fu_wrap = 1'b0;
`endif

  assign ram_addr  = mar;
  assign fu_ir     = ir;
  assign fu_mbr    = mbr;
  assign fu_pc     = pc;
  assign fu_icount = icount;
  assign fu_err    = err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized strobes against a behavioural model.
module tb_fetch_unit;
  logic fu_clk = 1'b0;
  logic fu_rst = 1'b1;
  logic mar_we = 0, mar_sel = 0, pc_inc = 0, pc_load = 0, mbr_we = 0, mbr_mux = 0, ir_we = 0, err_clr = 0;
  logic [7:0] pc_ld_val = 0, st_data = 0;
  logic [7:0] ram_rdata, ram_addr, fu_ir, fu_mbr, fu_pc;
  logic [15:0] fu_icount;
  logic fu_err, fu_wrap;
  logic [7:0] ram [256];

  int checks = 0, errors = 0;
  int m_pc, m_mar, m_mbr, m_ir, m_cnt, m_err, m_wrap;
  int wrap_en;

  always #5 fu_clk = ~fu_clk;
  assign ram_rdata = ram[ram_addr];

  fetch_unit dut (
    .fu_clk(fu_clk), .fu_rst(fu_rst), .mar_we(mar_we), .mar_sel(mar_sel), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_ld_val(pc_ld_val), .mbr_we(mbr_we), .mbr_mux(mbr_mux), .st_data(st_data),
    .ir_we(ir_we), .ram_rdata(ram_rdata), .err_clr(err_clr), .ram_addr(ram_addr), .fu_ir(fu_ir),
    .fu_mbr(fu_mbr), .fu_pc(fu_pc), .fu_icount(fu_icount), .fu_err(fu_err), .fu_wrap(fu_wrap)
  );

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_mbr = 0; m_ir = 0; m_cnt = 0; m_err = 0; m_wrap = 0;
  endtask

  // Drive one cycle of strobes, advance the model from pre-edge state, sample 1 time unit after the edge.
  task automatic cyc(input logic mw, ms, pi, pl, input logic [7:0] plv,
                     input logic mbw, mm, input logic [7:0] sd, input logic iw, ec);
    int n_pc, n_mar, n_mbr, n_ir, n_cnt, n_err, n_wrap;
    bit e;
    mar_we = mw; mar_sel = ms; pc_inc = pi; pc_load = pl; pc_ld_val = plv;
    mbr_we = mbw; mbr_mux = mm; st_data = sd; ir_we = iw; err_clr = ec;
    n_mar = mw ? (ms ? (m_ir % 16) : m_pc) : m_mar;
    n_pc  = pl ? int'(plv) : (pi ? (m_pc + 1) % 256 : m_pc);
    n_mbr = mbw ? (mm ? int'(sd) : int'(ram[m_mar])) : m_mbr;
    n_ir  = iw ? m_mbr : m_ir;
    n_cnt = (iw && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    e = (pl && pi) || (mw && ms && m_ir == 0);
    n_err = e ? 1 : (ec ? 0 : m_err);
    n_wrap = (wrap_en != 0 && pi && !pl && m_pc == 255) ? 1 : (ec ? 0 : m_wrap);
    @(posedge fu_clk); #1;
    m_pc = n_pc; m_mar = n_mar; m_mbr = n_mbr; m_ir = n_ir; m_cnt = n_cnt; m_err = n_err; m_wrap = n_wrap;
    mar_we = 0; mar_sel = 0; pc_inc = 0; pc_load = 0; mbr_we = 0; mbr_mux = 0; ir_we = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    fu_rst = 1'b1; #2; fu_rst = 1'b0; model_reset();
    @(posedge fu_clk); #1;
  endtask

  task automatic test_reset();
    fu_rst = 1'b1; #1;
    checks++; if (fu_pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", fu_pc); end
    checks++; if (ram_addr !== 8'h00 || fu_mbr !== 8'h00 || fu_ir !== 8'h00) begin errors++;
      $display("FAIL reset_regs got mar=%h mbr=%h ir=%h want 00", ram_addr, fu_mbr, fu_ir); end
    checks++; if (fu_icount !== 16'd0 || fu_err !== 1'b0 || fu_wrap !== 1'b0) begin errors++;
      $display("FAIL reset_flags got cnt=%0d err=%b wrap=%b want 0", fu_icount, fu_err, fu_wrap); end
    do_reset();
  endtask

  task automatic test_fetch();
    cyc(1,0,0,0,0, 0,0,0, 0,0);
    checks++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL fetch_mar got %h want 00", ram_addr); end
    cyc(0,0,1,0,0, 1,0,0, 0,0);
    checks++; if (fu_mbr !== 8'h4A || fu_pc !== 8'h01) begin errors++;
      $display("FAIL fetch_mbr got mbr=%h pc=%h want 4a 01", fu_mbr, fu_pc); end
    checks++; if (fu_ir !== 8'h00) begin errors++; $display("FAIL fetch_ir_early got %h want 00", fu_ir); end
    cyc(0,0,0,0,0, 0,0,0, 1,0);
    checks++; if (fu_ir !== 8'h4A || fu_pc !== 8'h01 || fu_icount !== 16'd1) begin errors++;
      $display("FAIL fetch_ir got ir=%h pc=%h cnt=%0d want 4a 01 1", fu_ir, fu_pc, fu_icount); end
  endtask

  task automatic test_operand();
    cyc(0,0,0,1,8'h30, 0,0,0, 0,0);
    cyc(1,0,0,0,0, 0,0,0, 0,0);
    cyc(0,0,1,0,0, 1,0,0, 0,0);
    cyc(0,0,0,0,0, 0,0,0, 1,0);
    checks++; if (fu_ir !== 8'h15) begin errors++; $display("FAIL operand_ir got %h want 15", fu_ir); end
    cyc(1,1,0,0,0, 0,0,0, 0,0);
    checks++; if (ram_addr !== 8'h05 || fu_err !== 1'b0) begin errors++;
      $display("FAIL operand_addr got %h err=%b want 05 0", ram_addr, fu_err); end
    cyc(0,0,0,0,0, 1,0,0, 0,0);
    checks++; if (fu_mbr !== ram[5]) begin errors++; $display("FAIL operand_mbr got %h want %h", fu_mbr, ram[5]); end
  endtask

  task automatic test_store();
    cyc(0,0,0,0,0, 1,1,8'hC3, 0,0);
    checks++; if (fu_mbr !== 8'hC3) begin errors++; $display("FAIL store_mbr got %h want c3", fu_mbr); end
    cyc(0,0,0,0,0, 1,1,8'h11, 1,0);
    checks++; if (fu_ir !== 8'hC3 || fu_mbr !== 8'h11) begin errors++;
      $display("FAIL store_rbw got ir=%h mbr=%h want c3 11", fu_ir, fu_mbr); end
  endtask

  task automatic test_conflict();
    cyc(0,0,1,1,8'h20, 0,0,0, 0,0);
    checks++; if (fu_pc !== 8'h20 || fu_err !== 1'b1) begin errors++;
      $display("FAIL conflict got pc=%h err=%b want 20 1", fu_pc, fu_err); end
    cyc(0,0,0,0,0, 0,0,0, 0,1);
    checks++; if (fu_err !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", fu_err); end
    cyc(0,0,1,1,8'h21, 0,0,0, 0,1);
    checks++; if (fu_err !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", fu_err); end
    cyc(0,0,0,0,0, 0,0,0, 0,1);
    do_reset();
    cyc(1,1,0,0,0, 0,0,0, 0,0);
    checks++; if (fu_err !== 1'b1 || ram_addr !== 8'h00) begin errors++;
      $display("FAIL early_operand got err=%b mar=%h want 1 00", fu_err, ram_addr); end
    cyc(0,0,0,0,0, 0,0,0, 0,1);
  endtask

  task automatic test_wrap();
    cyc(0,0,0,1,8'hFF, 0,0,0, 0,0);
    checks++; if (fu_wrap !== 1'b0) begin errors++; $display("FAIL wrap_load got %b want 0", fu_wrap); end
    cyc(0,0,1,0,0, 0,0,0, 0,0);
    checks++; if (fu_pc !== 8'h00 || fu_wrap !== wrap_en[0]) begin errors++;
      $display("FAIL wrap got pc=%h wrap=%b want 00 %0d", fu_pc, fu_wrap, wrap_en); end
    cyc(0,0,1,0,0, 0,0,0, 0,0);
    checks++; if (fu_wrap !== wrap_en[0]) begin errors++; $display("FAIL wrap_sticky got %b want %0d", fu_wrap, wrap_en); end
    cyc(0,0,0,0,0, 0,0,0, 0,1);
    checks++; if (fu_wrap !== 1'b0) begin errors++; $display("FAIL wrap_clr got %b want 0", fu_wrap); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1,0,0,0,0, 0,0,0, 0,0);
    cyc(0,0,1,0,0, 1,0,0, 0,0);
    #3 fu_rst = 1'b1; #1;
    checks++; if (fu_pc !== 8'h00 || fu_mbr !== 8'h00 || ram_addr !== 8'h00 || fu_ir !== 8'h00 ||
                  fu_icount !== 16'd0 || fu_err !== 1'b0 || fu_wrap !== 1'b0) begin errors++;
      $display("FAIL async_reset got pc=%h mbr=%h mar=%h ir=%h want 00", fu_pc, fu_mbr, ram_addr, fu_ir); end
    #1 fu_rst = 1'b0; model_reset();
    @(posedge fu_clk); #1;
    cyc(0,0,0,0,0, 0,0,0, 1,0);
    checks++; if (fu_ir !== 8'h00 || fu_icount !== 16'd1) begin errors++;
      $display("FAIL post_reset_ir got ir=%h cnt=%0d want 00 1", fu_ir, fu_icount); end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0,3) == 0, $urandom_range(0,1), $urandom_range(0,2) == 0, $urandom_range(0,7) == 0,
          8'($urandom), $urandom_range(0,2) == 0, $urandom_range(0,3) == 0, 8'($urandom),
          $urandom_range(0,3) == 0, $urandom_range(0,9) == 0);
      checks++;
      if (fu_pc !== 8'(m_pc) || ram_addr !== 8'(m_mar) || fu_mbr !== 8'(m_mbr) || fu_ir !== 8'(m_ir) ||
          fu_icount !== 16'(m_cnt) || fu_err !== 1'(m_err) || fu_wrap !== 1'(m_wrap)) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random[%0d] got pc=%h mar=%h mbr=%h ir=%h cnt=%0d err=%b wrap=%b want %h %h %h %h %0d %0d %0d",
                   i, fu_pc, ram_addr, fu_mbr, fu_ir, fu_icount, fu_err, fu_wrap,
                   m_pc, m_mar, m_mbr, m_ir, m_cnt, m_err, m_wrap);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65534; i++) cyc(0,0,0,0,0, 0,0,0, 1,0);
    checks++; if (fu_icount !== 16'd65534) begin errors++; $display("FAIL cnt_near_max got %0d want 65534", fu_icount); end
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,0, 0,0,0, 1,0);
    checks++; if (fu_icount !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate got %0d want 65535", fu_icount); end
  endtask

  initial begin
`ifdef FU_PC_WRAP_FLAG_EN
    wrap_en = 1;
`else
    wrap_en = 0;
`endif
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h4A;
    ram[8'h30] = 8'h15;
    model_reset();
    test_reset();
    test_fetch();
    test_operand();
    test_store();
    test_conflict();
    test_wrap();
    test_async_reset();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
